neuron_layer_sched: RTL and testbench

Sequential scheduler that evaluates a layer of M threshold neurons using one shared weighted-sum accumulator. Neurons are processed one at a time and synapses one per clock. Each neuron output is the same function as the combinational neuron: axon = (Σ s[j]·w[j]) ≥ threshold. The block sits between the synapse/weight source and the next layer, and trades area for latency when M·N is large.

---
 rtl/neuron_layer_sched_if.sv | 41 ++++
 rtl/neuron_layer_sched.sv | 169 ++++++++++++++++
 tb/tb_neuron_layer_sched.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_layer_sched_if.sv
// neuron_layer_sched_if
// Bundles the layer scheduler's request/data inputs and its status/result
// outputs so that the source side and the scheduler connect through one port.
// The master drives start plus the synapse, weight and threshold vectors;
// the slave (the scheduler) returns busy, done and the registered axons.

interface neuron_layer_sched_if #(
    parameter int N = 4,
    parameter int M = 4,
    parameter int W = 32
);

    logic               start;
    logic [N-1:0]       synapses;
    logic [M*N*W-1:0]   weights;
    logic [M*W-1:0]     thresholds;
    logic               busy;
    logic               done;
    logic [M-1:0]       axons;

    modport master (
        output start,
        output synapses,
        output weights,
        output thresholds,
        input  busy,
        input  done,
        input  axons
    );

    modport slave (
        input  start,
        input  synapses,
        input  weights,
        input  thresholds,
        output busy,
        output done,
        output axons
    );

endinterface

// File: rtl/neuron_layer_sched.sv
// neuron_layer_sched
// Evaluates a layer of M threshold neurons with a single shared accumulator.
// A request captures the synapse vector, every weight and every threshold.
// Each neuron then spends N cycles accumulating, one synapse per clock, and
// one cycle comparing its sum against its threshold. The layer result is
// published to axons as a single M-bit update, together with a one-cycle
// done pulse. Only the captured copies are used during evaluation, so the
// source may change its inputs freely once start has been taken.

module neuron_layer_sched #(
    parameter int N = 4,
    parameter int M = 4,
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    neuron_layer_sched_if.slave   bus
);

    // Index widths never drop below one bit, so M=1 and N=1 still work.
    localparam int JW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    // The sum of N unsigned W-bit weights needs W+clog2(N) bits. One spare
    // bit is kept on top, so the accumulator can never wrap.
    localparam int AW = W + $clog2(N) + 1;

    localparam logic [JW-1:0] J_LAST = JW'(N - 1);
    localparam logic [IW-1:0] I_LAST = IW'(M - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        CMP,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Captured copies of the request, frozen for the whole evaluation.
    logic [N-1:0]      s_cap;
    logic [M*N*W-1:0]  w_cap;
    logic [M*W-1:0]    th_cap;

    // Neuron index i, synapse index j and the shared accumulator.
    logic [IW-1:0]     i;
    logic [JW-1:0]     j;
    logic [AW-1:0]     acc;

    // res collects per-neuron decisions; axons_q is the published result.
    logic [M-1:0]      res;
    logic [M-1:0]      res_final;
    logic [M-1:0]      axons_q;

    logic [W-1:0]      w_sel;
    logic [W-1:0]      w_add;
    logic [W-1:0]      th_sel;
    logic              ge;
    logic              busy_c;
    logic              done_c;

    // Select this cycle's weight and threshold, and form the compare result.
    // The threshold is zero-extended to the accumulator width.
    always_comb begin
        w_sel     = w_cap[(int'(i) * N + int'(j)) * W +: W];
        w_add     = s_cap[j] ? w_sel : '0;
        th_sel    = th_cap[int'(i) * W +: W];
        ge        = (acc >= {{(AW-W){1'b0}}, th_sel});
        res_final = res;
        res_final[i] = ge;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the Moore status outputs.
    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                busy_c = 1'b1;
                if (j == J_LAST) begin
                    state_next = CMP;
                end
            end
            CMP: begin
                busy_c = 1'b1;
                if (i == I_LAST) begin
                    state_next = DONE;
                end else begin
                    state_next = ACC;
                end
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture, accumulate, compare and publish the layer result.
    // The final compare writes axons directly, so the new result is already
    // visible during the DONE cycle that carries the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cap   <= '0;
            w_cap   <= '0;
            th_cap  <= '0;
            i       <= '0;
            j       <= '0;
            acc     <= '0;
            res     <= '0;
            axons_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        s_cap  <= bus.synapses;
                        w_cap  <= bus.weights;
                        th_cap <= bus.thresholds;
                        acc    <= '0;
                        i      <= '0;
                        j      <= '0;
                    end
                end
                ACC: begin
                    acc <= acc + {{(AW-W){1'b0}}, w_add};
                    if (j != J_LAST) begin
                        j <= j + JW'(1);
                    end
                end
                CMP: begin
                    res <= res_final;
                    acc <= '0;
                    j   <= '0;
                    if (i == I_LAST) begin
                        axons_q <= res_final;
                    end else begin
                        i <= i + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.axons = axons_q;

endmodule

// File: tb/tb_neuron_layer_sched.sv
// tb_neuron_layer_sched
// Directed bench for the layer scheduler with M=2, N=4, W=32.
// A timeline model tracks when a request is accepted and what the layer
// must produce, computed straight from the weighted-sum rule. busy, done and
// axons are compared against that model on every falling clock edge.
// Directed runs add literal expectations for latency, results and the
// reset / disturbance cases.

module tb_neuron_layer_sched;

    localparam int N   = 4;
    localparam int M   = 2;
    localparam int W   = 32;
    localparam int LAT = M * (N + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks      = 0;
    int errors      = 0;
    int done_seen   = 0;
    int busy_cycles = 0;
    bit check_en    = 1'b0;

    // Model state: cycles since an accepted start (0 = free), pending result.
    int           m_cnt     = 0;
    logic [M-1:0] m_axons   = '0;
    logic [M-1:0] m_pending = '0;

    neuron_layer_sched_if #(.N(N), .M(M), .W(W)) bus ();

    neuron_layer_sched #(.N(N), .M(M), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Weighted sum of neuron i for a given input vector and weight set.
    function automatic logic [63:0] neuron_sum(input int ni, input logic [N-1:0] s,
                                               input logic [M*N*W-1:0] wv);
        logic [63:0] sum;
        sum = 64'd0;
        for (int jj = 0; jj < N; jj++) begin
            if (s[jj]) sum = sum + {32'd0, wv[(ni*N+jj)*W +: W]};
        end
        return sum;
    endfunction

    // Layer result: each neuron fires when its sum reaches its threshold.
    function automatic logic [M-1:0] model_axons(input logic [N-1:0] s,
                                                 input logic [M*N*W-1:0] wv,
                                                 input logic [M*W-1:0] tv);
        logic [M-1:0] r;
        r = '0;
        for (int ni = 0; ni < M; ni++) begin
            r[ni] = (neuron_sum(ni, s, wv) >= {32'd0, tv[ni*W +: W]});
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Timeline model: a start is taken only when no run is in flight; the
    // result appears LAT edges later and the block is free two edges after.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_axons <= '0;
        end else if (m_cnt == 0) begin
            if (bus.start) begin
                m_pending <= model_axons(bus.synapses, bus.weights, bus.thresholds);
                m_cnt     <= 1;
            end
        end else begin
            if (m_cnt == LAT) m_axons <= m_pending;
            m_cnt <= (m_cnt == LAT + 1) ? 0 : m_cnt + 1;
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("busy",  {63'd0, bus.busy}, {63'd0, (m_cnt >= 1 && m_cnt <= LAT)});
            checkOutput("done",  {63'd0, bus.done}, {63'd0, (m_cnt == LAT + 1)});
            checkOutput("axons", {62'd0, bus.axons}, {62'd0, m_axons});
        end
    end

    // Event counters used by the directed checks.
    always @(negedge clk) begin
        if (bus.done) done_seen <= done_seen + 1;
        if (bus.busy) busy_cycles <= busy_cycles + 1;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic loadBaseWeights();
        bus.weights    = '0;
        for (int jj = 0; jj < N; jj++) begin
            bus.weights[(0*N+jj)*W +: W] = W'(1 << jj);
            bus.weights[(1*N+jj)*W +: W] = W'(1);
        end
        bus.thresholds = '0;
        bus.thresholds[0*W +: W] = W'(2);
        bus.thresholds[1*W +: W] = W'(3);
    endtask

    // Wait for done with a bound; waited counts rising edges passed.
    task automatic waitDone(output int waited);
        waited = 0;
        while (!bus.done && waited < 50) begin
            @(posedge clk);
            waited++;
            @(negedge clk);
        end
        if (!bus.done) begin
            errors++;
            $display("[TB] FAIL wait_done actual=no_done expected=done");
        end
    endtask

    // One full run: pulse start with syn, then wait for done.
    task automatic applyStimulus(input logic [N-1:0] syn, output int lat);
        @(negedge clk);
        bus.synapses = syn;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(lat);
    endtask

    initial begin
        int lat;
        int w;
        int done0;
        int busy0;

        bus.start    = 1'b0;
        bus.synapses = '0;
        loadBaseWeights();

        // Pin the model with hand-computed results.
        checkOutput("model_0011", {62'd0, model_axons(4'b0011, bus.weights, bus.thresholds)}, 64'h1);
        checkOutput("model_0111", {62'd0, model_axons(4'b0111, bus.weights, bus.thresholds)}, 64'h3);
        checkOutput("model_0010", {62'd0, model_axons(4'b0010, bus.weights, bus.thresholds)}, 64'h1);
        checkOutput("model_sum0_0111", neuron_sum(0, 4'b0111, bus.weights), 64'd7);

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_busy",  {63'd0, bus.busy}, 64'h0);
        checkOutput("reset_done",  {63'd0, bus.done}, 64'h0);
        checkOutput("reset_axons", {62'd0, bus.axons}, 64'h0);
        check_en = 1'b1;
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero input: latency and busy window.
        busy0 = busy_cycles;
        applyStimulus(4'b0000, lat);
        checkOutput("lat_0000",   lat, 64'd10);
        checkOutput("axons_0000", {62'd0, bus.axons}, 64'h0);
        @(negedge clk);
        checkOutput("busy_cycles", busy_cycles - busy0, 64'd10);

        applyStimulus(4'b0011, lat);
        checkOutput("lat_0011",   lat, 64'd10);
        checkOutput("axons_0011", {62'd0, bus.axons}, 64'h1);

        applyStimulus(4'b0111, lat);
        checkOutput("axons_0111", {62'd0, bus.axons}, 64'h3);

        applyStimulus(4'b0010, lat);
        checkOutput("axons_0010", {62'd0, bus.axons}, 64'h1);

        applyStimulus(4'b0001, lat);
        checkOutput("axons_0001", {62'd0, bus.axons}, 64'h0);

        // Overflow: largest weights, accumulator must not wrap.
        @(negedge clk);
        bus.weights    = '1;
        bus.thresholds = '0;
        bus.thresholds[0*W +: W] = 32'hFFFF_FFFF;
        checkOutput("model_sum_ovf", neuron_sum(0, 4'b1111, bus.weights), 64'h3_FFFF_FFFC);
        applyStimulus(4'b1111, lat);
        checkOutput("lat_ovf",   lat, 64'd10);
        checkOutput("axons_ovf", {62'd0, bus.axons}, 64'h3);
        @(negedge clk);
        loadBaseWeights();
        applyStimulus(4'b0000, lat);
        checkOutput("axons_clear", {62'd0, bus.axons}, 64'h0);

        // Mid-run disturbance: second start and new inputs are ignored.
        @(negedge clk);
        done0 = done_seen;
        bus.synapses = 4'b0111;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.synapses = 4'b0000;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(w);
        checkOutput("disturb_lat",   w + 3, 64'd10);
        checkOutput("disturb_axons", {62'd0, bus.axons}, 64'h3);
        repeat (20) @(negedge clk);
        checkOutput("disturb_dones", done_seen - done0, 64'd1);

        // Reset in the middle of a run.
        done0 = done_seen;
        bus.synapses = 4'b0111;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy",  {63'd0, bus.busy}, 64'h0);
        checkOutput("midrst_axons", {62'd0, bus.axons}, 64'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (14) @(negedge clk);
        checkOutput("midrst_dones", done_seen - done0, 64'd0);
        checkOutput("midrst_axons_hold", {62'd0, bus.axons}, 64'h0);

        applyStimulus(4'b0111, lat);
        checkOutput("post_rst_lat",   lat, 64'd10);
        checkOutput("post_rst_axons", {62'd0, bus.axons}, 64'h3);

        repeat (4) @(negedge clk);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
